// File: rtl/seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | seq_alu: clocked ALU with iterative multiply/divide and registered flags |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module seq_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             valid,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             sign,
  output logic             over,
  output logic             dbz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [SHW-1:0] c_last_iter = SHW'(WIDTH - 1);

  state_t             r_state;
  logic [3:0]         r_func;
  logic [WIDTH-1:0]   r_opnd;
  logic [2*WIDTH-1:0] r_acc;
  logic [SHW-1:0]     r_cnt;

  logic [WIDTH-1:0]   w_sum, w_dif, w_res;
  logic [SHW-1:0]     w_sh;
  logic               w_big, w_over, w_dbz, w_multi;

  assign w_sum = a + b;
  assign w_dif = a - b;
  assign w_sh  = b[SHW-1:0];
  assign w_big = |(b >> SHW);

  always_comb begin
    w_res   = '0;
    w_over  = 1'b0;
    w_dbz   = 1'b0;
    w_multi = 1'b0;
    case (func)
      4'd0: begin
        w_res  = w_sum;
        w_over = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      4'd1: begin
        w_res  = w_dif;
        w_over = (a[WIDTH-1] != b[WIDTH-1]) && (w_dif[WIDTH-1] != a[WIDTH-1]);
      end
      4'd2: w_res = a & b;
      4'd3: w_res = a | b;
      4'd4: w_res = a ^ b;
      4'd5: w_res = ~a;
      4'd6: w_res = w_big ? '0 : (a << w_sh);
      4'd7: w_res = w_big ? {WIDTH{a[WIDTH-1]}} : ($signed(a) >>> w_sh);
      4'd8: w_res = w_big ? '0 : (a >> w_sh);
      4'd9: w_multi = 1'b1;
      4'd10: begin
        if (b == '0) begin
          w_res = '1;
          w_dbz = 1'b1;
        end else begin
          w_multi = 1'b1;
        end
      end
      4'd11: begin
        if (b == '0) begin
          w_res = a;
          w_dbz = 1'b1;
        end else begin
          w_multi = 1'b1;
        end
      end
      4'd12: w_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: w_res = '0;
    endcase
  end

  // One iteration step: shift-add for multiply, restoring shift-subtract for divide
  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_div_try;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_next;
  logic [WIDTH-1:0]   w_fin;
  logic               w_is_mul;

  assign w_is_mul   = (r_func == 4'd9);
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};
  assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_div_try  = w_rem_sh - {1'b0, r_opnd};
  assign w_div_next = w_div_try[WIDTH]
                    ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                    : {w_div_try[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
  assign w_next     = w_is_mul ? w_mul_next : w_div_next;
  assign w_fin      = (r_func == 4'd11) ? w_next[2*WIDTH-1:WIDTH] : w_next[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_func  <= '0;
      r_opnd  <= '0;
      r_acc   <= '0;
      r_cnt   <= '0;
      ready   <= 1'b1;
      valid   <= 1'b0;
      out     <= '0;
      zero    <= 1'b0;
      sign    <= 1'b0;
      over    <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          valid <= 1'b0;
          if (start) begin
            if (w_multi) begin
              r_state <= BUSY;
              ready   <= 1'b0;
              r_func  <= func;
              r_opnd  <= (func == 4'd9) ? a : b;
              r_acc   <= {{WIDTH{1'b0}}, ((func == 4'd9) ? b : a)};
              r_cnt   <= '0;
            end else begin
              valid <= 1'b1;
              out   <= w_res;
              zero  <= (w_res == '0);
              sign  <= w_res[WIDTH-1];
              over  <= w_over;
              dbz   <= w_dbz;
            end
          end
        end
        BUSY: begin
          r_acc <= w_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == c_last_iter) begin
            r_state <= DONE;
            valid   <= 1'b1;
            out     <= w_fin;
            zero    <= (w_fin == '0);
            sign    <= w_fin[WIDTH-1];
            over    <= w_is_mul && (|w_next[2*WIDTH-1:WIDTH]);
            dbz     <= 1'b0;
          end
        end
        DONE: begin
          r_state <= IDLE;
          valid   <= 1'b0;
          ready   <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          valid   <= 1'b0;
          ready   <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_seq_alu: directed self-checking bench for seq_alu, WIDTH=32 and 8     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_seq_alu;

  logic        clk;
  logic        rst_n;

  logic        start32, ready32, valid32, zero32, sign32, over32, dbz32;
  logic [3:0]  func32;
  logic [31:0] a32, b32, out32;

  logic        start8, ready8, valid8, zero8, sign8, over8, dbz8;
  logic [3:0]  func8;
  logic [7:0]  a8, b8, out8;

  int n_tests = 0;
  int n_fail  = 0;
  int vl, rl, lowcnt;

  seq_alu #(.WIDTH(32)) u_alu32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .func(func32), .a(a32), .b(b32),
    .ready(ready32), .valid(valid32), .out(out32), .zero(zero32), .sign(sign32),
    .over(over32), .dbz(dbz32)
  );

  seq_alu #(.WIDTH(8)) u_alu8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .func(func8), .a(a8), .b(b8),
    .ready(ready8), .valid(valid8), .out(out8), .zero(zero8), .sign(sign8),
    .over(over8), .dbz(dbz8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one request for exactly one acceptance edge, return #1 after it
  task automatic issue(input bit s8, input logic [3:0] f, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    if (s8) begin
      start8 = 1'b1; func8 = f; a8 = av[7:0]; b8 = bv[7:0];
    end else begin
      start32 = 1'b1; func32 = f; a32 = av; b32 = bv;
    end
    @(posedge clk);
    #1;
    start8  = 1'b0;
    start32 = 1'b0;
  endtask

  // Edges after acceptance until valid (vlat) and until ready (rlat); -1 on timeout
  task automatic wait_done(input bit s8, output int vlat, output int rlat);
    vlat = -1;
    rlat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      #1;
      if ((s8 ? valid8 : valid32) && vlat < 0) vlat = i;
      if (s8 ? ready8 : ready32) begin
        rlat = i;
        break;
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    start32 = 1'b0; func32 = '0; a32 = '0; b32 = '0;
    start8  = 1'b0; func8  = '0; a8  = '0; b8  = '0;
    #12;
    check("rst_ready", ready32, 1);
    check("rst_valid", valid32, 0);
    check("rst_out",   out32, 0);
    check("rst_flags", {zero32, sign32, over32, dbz32}, 4'b0000);
    check("rst8_ready", ready8, 1);
    check("rst8_out",   out8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    issue(0, 4'd0, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_out", out32, 64'h8000_0000);
    check("add_ovf_flags", {zero32, sign32, over32}, 3'b011);
    check("add_ovf_valid", valid32, 1);
    @(posedge clk); #1;
    check("add_ovf_valid_drop", valid32, 0);

    issue(0, 4'd1, 32'h8000_0000, 32'h1);
    check("sub_ovf_out", out32, 64'h7FFF_FFFF);
    check("sub_ovf_over", over32, 1);

    // Back-to-back single-cycle ops
    @(negedge clk);
    start32 = 1'b1; func32 = 4'd1; a32 = 5; b32 = 5;
    @(posedge clk); #1;
    check("b2b_sub_out", out32, 0);
    check("b2b_sub_zero", zero32, 1);
    check("b2b_sub_vr", {valid32, ready32}, 2'b11);
    func32 = 4'd0; a32 = 2; b32 = 3;
    @(posedge clk); #1;
    start32 = 1'b0;
    check("b2b_add_out", out32, 5);
    check("b2b_add_zero", zero32, 0);
    check("b2b_add_vr", {valid32, ready32}, 2'b11);
    @(posedge clk); #1;
    check("b2b_valid_drop", valid32, 0);

    // Multiply with an ignored mid-op start
    issue(0, 4'd9, 32'h0001_0000, 32'h0001_0000);
    check("mul_ready_low", ready32, 0);
    vl = -1; rl = -1; lowcnt = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk); #1;
      if (i == 5) begin
        start32 = 1'b1; func32 = 4'd0; a32 = 0; b32 = 7;
      end
      if (i == 6) start32 = 1'b0;
      if (valid32 && vl < 0) vl = i;
      if (ready32) begin
        rl = i;
        break;
      end
      lowcnt++;
    end
    check("mul_vlat", vl, 32);
    check("mul_rlat", rl, 33);
    check("mul_ready_low_cnt", lowcnt, 32);
    check("mul_out", out32, 0);
    check("mul_flags", {zero32, sign32, over32}, 3'b101);
    check("mul_valid_after", valid32, 0);

    issue(0, 4'd10, 100, 7);
    wait_done(0, vl, rl);
    check("divu_out", out32, 14);
    check("divu_dbz", dbz32, 0);
    check("divu_lat", {vl[15:0], rl[15:0]}, {16'd32, 16'd33});

    issue(0, 4'd11, 100, 7);
    wait_done(0, vl, rl);
    check("remu_out", out32, 2);
    check("remu_lat", rl, 33);

    issue(0, 4'd10, 7, 0);
    check("div0_out", out32, 64'hFFFF_FFFF);
    check("div0_dbz", dbz32, 1);
    check("div0_vr", {valid32, ready32}, 2'b11);

    issue(0, 4'd11, 7, 0);
    check("rem0_out", out32, 7);

    issue(0, 4'd7, 32'h8000_0000, 40);
    check("sra_big_out", out32, 64'hFFFF_FFFF);
    check("sra_big_sign_dbz", {sign32, dbz32}, 2'b10);

    issue(0, 4'd8, 32'h8000_0000, 40);
    check("srl_big_out", out32, 0);
    check("srl_big_zero", zero32, 1);

    issue(0, 4'd12, 32'hFFFF_FFFF, 0);
    check("slt32_out", out32, 1);

    issue(0, 4'd14, 32'h1234, 32'h5678);
    check("illegal_out", out32, 0);
    check("illegal_flags", {zero32, sign32, over32, dbz32}, 4'b1000);

    issue(0, 4'd6, 32'h1, 31);
    check("sll_out", out32, 64'h8000_0000);
    check("sll_sign", sign32, 1);

    // Async reset mid-multiply
    issue(0, 4'd9, 3, 5);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort_ready", ready32, 1);
    check("abort_valid", valid32, 0);
    check("abort_out", out32, 0);
    check("abort_flags", {zero32, sign32, over32, dbz32}, 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    issue(0, 4'd0, 1, 1);
    check("post_reset_add", out32, 2);

    // WIDTH=8 instance
    issue(1, 4'd9, 8'h10, 8'h10);
    check("mul8_ready_low", ready8, 0);
    wait_done(1, vl, rl);
    check("mul8_lat", {vl[15:0], rl[15:0]}, {16'd8, 16'd9});
    check("mul8_out", out8, 0);
    check("mul8_flags", {zero8, over8}, 2'b11);

    issue(1, 4'd12, 8'hFF, 8'h00);
    check("slt8_out", out8, 1);

    issue(1, 4'd10, 8'd200, 8'd9);
    wait_done(1, vl, rl);
    check("divu8_out", out8, 22);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
